// File: rtl/memory_round_ctrl.sv
// rtl/memory_round_ctrl.sv - memory game round sequencer
// Plays back the symbol sequence, times the player's replies and owns the score.
module memory_round_ctrl #(
  parameter int CW      = 28,
  parameter int SW      = 8,
  parameter int KW      = 2,
  parameter int MAX_LEN = 16,
  parameter int GAP_CYC = 4
) (
  input  logic          clock_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic [CW-1:0] count_value_i,
  input  logic [KW-1:0] pattern_code_i,
  input  logic          btn_valid_i,
  input  logic [KW-1:0] btn_code_i,
  output logic [SW-1:0] p_score_o,
  output logic [SW-1:0] seq_index_o,
  output logic          show_on_o,
  output logic          input_en_o,
  output logic          round_win_o,
  output logic          game_over_o,
  output logic          timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SHOW,
    S_GAP,
    S_INPUT,
    S_ADVANCE,
    S_OVER
  } state_e;

  localparam logic [SW-1:0] LAST_CAP  = SW'(MAX_LEN - 1);
  localparam logic [SW-1:0] SCORE_MAX = '1;
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYC - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] score_q, score_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;

  logic [SW-1:0] last_idx;
  logic          expired;
  logic          press_ok;

  // Sequence length is score+1 capped at MAX_LEN; last_idx is that length minus one.
  assign last_idx = (score_q >= LAST_CAP) ? LAST_CAP : score_q;
  assign expired  = (timer_q == '0);
  assign press_ok = (btn_code_i == pattern_code_i);

  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      score_q   <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_i) begin
          score_d = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        idx_d   = '0;
        timer_d = count_value_i;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (expired) begin
          timer_d = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end
      S_GAP: begin
        if (expired) begin
          timer_d = count_value_i;
          if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + SW'(1);
            state_d = S_SHOW;
          end
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end
      S_INPUT: begin
        // A press on the expiry cycle still counts, so presses are decoded first.
        if (btn_valid_i) begin
          if (!press_ok) begin
            state_d = S_OVER;
          end else if (idx_q == last_idx) begin
            state_d = S_ADVANCE;
          end else begin
            idx_d   = idx_q + SW'(1);
            timer_d = count_value_i;
          end
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = S_OVER;
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end
      S_ADVANCE: begin
        score_d = (score_q == SCORE_MAX) ? score_q : score_q + SW'(1);
        state_d = S_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign p_score_o   = score_q;
  assign seq_index_o = idx_q;
  assign show_on_o   = (state_q == S_SHOW);
  assign input_en_o  = (state_q == S_INPUT);
  assign round_win_o = (state_q == S_ADVANCE);
  assign game_over_o = (state_q == S_OVER);
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_memory_round_ctrl.sv
// tb/tb_memory_round_ctrl.sv - randomized bench for memory_round_ctrl
// Expected outputs are generated per cycle from the game rules as a trace, then replayed.
module tb_memory_round_ctrl;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [27:0] count_value;
  logic [1:0]  pattern_code;
  logic        btn_valid;
  logic [1:0]  btn_code;
  logic [7:0]  p_score;
  logic [7:0]  seq_index;
  logic        show_on, input_en, round_win, game_over, timeout;

  logic [1:0]  pat [16];

  typedef struct {
    bit         st;
    bit         bv;
    logic [1:0] bc;
    int         cv;
    logic [20:0] exp_v;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   m_sc = 0;
  int   m_ix = 0;
  bit   m_over = 0;

  always #5 clk = ~clk;

  assign pattern_code = pat[seq_index[3:0]];

  memory_round_ctrl dut (
    .clock_i        (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .count_value_i  (count_value),
    .pattern_code_i (pattern_code),
    .btn_valid_i    (btn_valid),
    .btn_code_i     (btn_code),
    .p_score_o      (p_score),
    .seq_index_o    (seq_index),
    .show_on_o      (show_on),
    .input_en_o     (input_en),
    .round_win_o    (round_win),
    .game_over_o    (game_over),
    .timeout_o      (timeout)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  function automatic logic [20:0] mk(int sc, int ix, bit sh, bit ie, bit rw, bit go, bit to);
    return {8'(sc), 8'(ix), sh, ie, rw, go, to};
  endfunction

  function automatic logic [20:0] obs_vec();
    return {p_score, seq_index, show_on, input_en, round_win, game_over, timeout};
  endfunction

  task automatic add(bit st, bit bv, logic [1:0] bc, int cv, logic [20:0] e);
    ent_t x;
    x.st = st; x.bv = bv; x.bc = bc; x.cv = cv; x.exp_v = e;
    q.push_back(x);
  endtask

  // Start and button noise here must be ignored by the design.
  task automatic add_noise(int cv, logic [20:0] e);
    add($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 2'($urandom), cv, e);
  endtask

  task automatic add_in(int cv, int i);
    add($urandom_range(0, 7) == 0, 1'b0, 2'b00, cv, mk(m_sc, i, 0, 1, 0, 0, 0));
  endtask

  task automatic over_tail(int cv, int i, bit to);
    m_ix = i;
    m_over = 1;
    add(0, $urandom_range(0, 3) == 0, 2'($urandom), cv, mk(m_sc, i, 0, 0, 0, 1, to));
    add(0, $urandom_range(0, 3) == 0, 2'($urandom), cv, mk(m_sc, i, 0, 0, 0, 1, 0));
  endtask

  // One game: rounds-1 wins, then a wrong press or a timeout in the final round.
  task automatic gen_game(input int cv, input int rounds);
    int len, d, lose_at;
    for (int k = 0; k < 16; k++) pat[k] = 2'($urandom);
    for (int k = 0; k < 2; k++)
      add(0, $urandom_range(0, 3) == 0, 2'($urandom), cv, mk(m_sc, m_ix, 0, 0, 0, m_over, 0));
    add(1, 0, 2'b00, cv, mk(m_sc, m_ix, 0, 0, 0, m_over, 0));
    m_sc = 0;
    m_over = 0;
    for (int r = 0; r < rounds; r++) begin
      len = (m_sc >= 15) ? 16 : m_sc + 1;
      add_noise(cv, mk(m_sc, m_ix, 0, 0, 0, 0, 0));
      for (int i = 0; i < len; i++) begin
        for (int c = 0; c <= cv; c++) add_noise(cv, mk(m_sc, i, 1, 0, 0, 0, 0));
        for (int g = 0; g < GAP; g++) add_noise(cv, mk(m_sc, i, 0, 0, 0, 0, 0));
      end
      lose_at = (r == rounds - 1) ? $urandom_range(0, len - 1) : -1;
      for (int i = 0; i < len; i++) begin
        if (i == lose_at) begin
          if ($urandom_range(0, 1) == 1) begin
            d = $urandom_range(0, cv);
            for (int c = 0; c < d; c++) add_in(cv, i);
            add(0, 1, pat[i] ^ 2'($urandom_range(1, 3)), cv, mk(m_sc, i, 0, 1, 0, 0, 0));
            over_tail(cv, i, 0);
          end else begin
            for (int c = 0; c <= cv; c++) add_in(cv, i);
            over_tail(cv, i, 1);
          end
          return;
        end
        d = $urandom_range(0, cv);
        for (int c = 0; c < d; c++) add_in(cv, i);
        add(0, 1, pat[i], cv, mk(m_sc, i, 0, 1, 0, 0, 0));
      end
      add_noise(cv, mk(m_sc, len - 1, 0, 0, 1, 0, 0));
      m_ix = len - 1;
      if (m_sc < 255) m_sc++;
    end
  endtask

  task automatic run_q();
    ent_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      start       = x.st;
      btn_valid   = x.bv;
      btn_code    = x.bc;
      count_value = 28'(x.cv);
      @(negedge clk);
      check_eq($sformatf("cyc%0d", cyc), {43'd0, obs_vec()}, {43'd0, x.exp_v});
      cyc++;
      @(posedge clk);
      #1;
    end
    start = 0;
    btn_valid = 0;
  endtask

  // Starts a game, lets SHOW begin, then pulls reset mid-cycle.
  task automatic reset_mid_show();
    bit seen;
    count_value = 28'd3;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (show_on) seen = 1;
    end
    check_eq("show_reached", {63'd0, seen}, 64'd1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check_eq("reset_async", {43'd0, obs_vec()}, 64'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_eq("reset_hold", {43'd0, obs_vec()}, 64'd0);
    rst_n = 1;
    @(posedge clk); #1;
    m_sc = 0; m_ix = 0; m_over = 0;
  endtask

  initial begin
    rst_n = 0;
    start = 0;
    btn_valid = 0;
    btn_code = 0;
    count_value = 0;
    for (int k = 0; k < 16; k++) pat[k] = 2'(k);
    #1;
    check_eq("reset_state", {43'd0, obs_vec()}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    gen_game(3, 3); run_q();
    gen_game(5, 2); run_q();
    for (int g = 0; g < 6; g++) begin
      gen_game($urandom_range(0, 4), $urandom_range(1, 5));
      run_q();
    end
    reset_mid_show();
    gen_game(2, 3); run_q();
    gen_game(0, 260); run_q();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
